// File: rtl/lift_request_queue_pkg.sv
// lift_pkg: shared constants, FSM state type and floor encoder for the lift request queue.
package lift_pkg;
  localparam int NUM_FLOORS = 8;
  localparam int FLOOR_W = 3;
  localparam int CNT_W = 4;
  localparam int REQ_W = 4;
  localparam int DWELL_CYCLES = 4;
  localparam int DWELL_W = DWELL_CYCLES > 1 ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [REQ_W-1:0] IDLE_CODE = 4'hF;
  typedef enum logic [1:0] {IDLE, SETTLE, SERVE, DWELL} state_e;
  function automatic logic [FLOOR_W-1:0] lowest_floor(input logic [NUM_FLOORS-1:0] v);
    lowest_floor = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) if (v[i]) lowest_floor = FLOOR_W'(i);
  endfunction
endpackage

// File: rtl/lift_request_queue_if.sv
// lift_request_queue_if: button/controller-side bus of the request queue.
// btn, stop_in flow into the queue; req_floor, pending, count, busy flow out.
interface lift_request_queue_if;
  import lift_pkg::*;
  logic [NUM_FLOORS-1:0] btn;
  logic                  stop_in;
  logic [REQ_W-1:0]      req_floor;
  logic [NUM_FLOORS-1:0] pending;
  logic [CNT_W-1:0]      count;
  logic                  busy;
  modport master(output btn, stop_in, input req_floor, pending, count, busy);
  modport slave(input btn, stop_in, output req_floor, pending, count, busy);
endinterface

// File: rtl/lift_request_queue_floor_fifo.sv
// floor_fifo: 8-deep circular buffer of floor numbers.
// Ports: clk, reset, push/din write the tail, pop drops the head, head/count show state.
module floor_fifo
  import lift_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic [FLOOR_W-1:0] din,
  output logic [FLOOR_W-1:0] head,
  output logic [CNT_W-1:0]   count
);
  logic [FLOOR_W-1:0] mem_q [NUM_FLOORS];
  logic [FLOOR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  always_comb begin
    wptr_d = wptr_q + FLOOR_W'(push);
    rptr_d = rptr_q + FLOOR_W'(pop);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) if (push) mem_q[wptr_q] <= din;
  assign head = mem_q[rptr_q];
  assign count = count_q;
endmodule

// File: rtl/lift_request_queue.sv
// lift_request_queue: FCFS floor-call queue with duplicate suppression feeding the lift controller.
// Ports: clk, reset (sync, active-high), bus (slave): btn/stop_in in, req_floor/pending/count/busy out.
module lift_request_queue
  import lift_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  lift_request_queue_if.slave bus
);
  logic [NUM_FLOORS-1:0] btn_q, newreq_q, newreq_d, pending_q, pending_d;
  logic [NUM_FLOORS-1:0] rise, enq_bit, pop_bit;
  logic [REQ_W-1:0]      req_q, req_d;
  logic [DWELL_W-1:0]    dwell_q, dwell_d;
  logic [FLOOR_W-1:0]    din, head;
  logic [CNT_W-1:0]      count;
  logic                  push, pop;
  state_e                state_q, state_d;
  floor_fifo u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .din  (din),
    .head (head),
    .count(count)
  );
  // Pending bits exclude re-captures, so a press in the pop cycle of the same floor is dropped.
  always_comb begin
    rise = bus.btn & ~btn_q;
    push = |newreq_q;
    din = lowest_floor(newreq_q);
    enq_bit = push ? NUM_FLOORS'(1) << din : '0;
    pop = state_q == DWELL && dwell_q == '0;
    pop_bit = pop ? NUM_FLOORS'(1) << head : '0;
    newreq_d = (newreq_q & ~enq_bit) | (rise & ~pending_q & ~newreq_q);
    pending_d = (pending_q | enq_bit) & ~pop_bit;
  end
  always_comb begin
    state_d = state_q == IDLE   ? (count != '0 ? SETTLE : IDLE) :
              state_q == SETTLE ? SERVE :
              state_q == SERVE  ? (bus.stop_in ? DWELL : SERVE) :
              (dwell_q == '0 ? IDLE : DWELL);
  end
  always_comb begin
    req_d = state_q == IDLE && count != '0 ? REQ_W'(head) : pop ? IDLE_CODE : req_q;
    dwell_d = state_q == SERVE && bus.stop_in ? DWELL_W'(DWELL_CYCLES - 1) :
              state_q == DWELL && dwell_q != '0 ? dwell_q - DWELL_W'(1) : dwell_q;
  end
  always_ff @(posedge clk) state_q <= reset ? IDLE : state_d;
  // Loaded through reset so a button held across reset never looks like a fresh press.
  always_ff @(posedge clk) btn_q <= bus.btn;
  always_ff @(posedge clk) begin
    if (reset) begin
      newreq_q <= '0;
      pending_q <= '0;
      req_q <= IDLE_CODE;
      dwell_q <= '0;
    end else begin
      newreq_q <= newreq_d;
      pending_q <= pending_d;
      req_q <= req_d;
      dwell_q <= dwell_d;
    end
  end
  assign bus.req_floor = req_q;
  assign bus.pending = pending_q;
  assign bus.count = count;
  assign bus.busy = state_q != IDLE;
endmodule

// File: tb/tb_lift_request_queue.sv
// tb_lift_request_queue: directed self-checking bench for lift_request_queue.
module tb_lift_request_queue;
  logic clk = 1'b0;
  logic reset;
  int errors = 0;
  int checks = 0;
  lift_request_queue_if bus ();
  lift_request_queue dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  task automatic wait_target();
    for (int k = 0; k < 40 && bus.req_floor == 4'hF; k++) step();
  endtask
  task automatic serve_next(input int exp);
    wait_target();
    check("serve_floor", int'(bus.req_floor), exp);
    bus.stop_in = 1'b1;
    for (int k = 0; k < 40 && bus.req_floor != 4'hF; k++) step();
    check("served_idle", int'(bus.req_floor), 15);
    check("served_pending", int'(bus.pending[exp]), 0);
    bus.stop_in = 1'b0;
  endtask
  initial begin
    reset = 1'b1;
    bus.btn = '0;
    bus.stop_in = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    check("rst_req", int'(bus.req_floor), 15);
    check("rst_count", int'(bus.count), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_pending", int'(bus.pending), 0);
    // single press of floor 5
    bus.btn = 8'h20;
    step();
    bus.btn = '0;
    check("t1_capture_count", int'(bus.count), 0);
    step();
    check("t1_enq_count", int'(bus.count), 1);
    check("t1_enq_pending", int'(bus.pending), 'h20);
    check("t1_req_before", int'(bus.req_floor), 15);
    step();
    check("t1_req", int'(bus.req_floor), 5);
    check("t1_busy", int'(bus.busy), 1);
    bus.stop_in = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("t1_hold", int'(bus.req_floor), 5);
    end
    step();
    check("t1_done_req", int'(bus.req_floor), 15);
    check("t1_done_pending", int'(bus.pending), 0);
    check("t1_done_count", int'(bus.count), 0);
    check("t1_done_busy", int'(bus.busy), 0);
    bus.stop_in = 1'b0;
    // simultaneous presses 6, 2, 4
    bus.btn = 8'h54;
    step();
    bus.btn = '0;
    check("t2_count0", int'(bus.count), 0);
    step();
    check("t2_count1", int'(bus.count), 1);
    step();
    check("t2_count2", int'(bus.count), 2);
    step();
    check("t2_count3", int'(bus.count), 3);
    check("t2_pending", int'(bus.pending), 'h54);
    serve_next(2);
    serve_next(4);
    serve_next(6);
    // duplicate press of floor 3
    bus.btn = 8'h08;
    step();
    bus.btn = '0;
    step();
    step();
    bus.btn = 8'h08;
    step();
    bus.btn = '0;
    step();
    step();
    check("t3_count", int'(bus.count), 1);
    check("t3_pending", int'(bus.pending), 'h08);
    serve_next(3);
    repeat (6) step();
    check("t3_once_req", int'(bus.req_floor), 15);
    check("t3_once_count", int'(bus.count), 0);
    // all eight floors, no service until full
    for (int i = 0; i < 8; i++) begin
      bus.btn = 8'h01 << i;
      step();
    end
    bus.btn = '0;
    repeat (3) step();
    check("t4_count", int'(bus.count), 8);
    check("t4_pending", int'(bus.pending), 'hFF);
    for (int i = 0; i < 8; i++) serve_next(i);
    check("t4_empty", int'(bus.count), 0);
    // reset during DWELL, with floor 7 held across reset
    bus.btn = 8'h0E;
    step();
    bus.btn = '0;
    wait_target();
    check("t5_target", int'(bus.req_floor), 1);
    bus.stop_in = 1'b1;
    repeat (3) step();
    check("t5_count_pre", int'(bus.count), 3);
    check("t5_busy_pre", int'(bus.busy), 1);
    reset = 1'b1;
    bus.btn = 8'h80;
    step();
    reset = 1'b0;
    bus.stop_in = 1'b0;
    check("t5_rst_req", int'(bus.req_floor), 15);
    check("t5_rst_count", int'(bus.count), 0);
    check("t5_rst_busy", int'(bus.busy), 0);
    check("t5_rst_pending", int'(bus.pending), 0);
    repeat (4) step();
    check("t5_held_count", int'(bus.count), 0);
    check("t5_held_req", int'(bus.req_floor), 15);
    bus.btn = '0;
    step();
    bus.btn = 8'h80;
    step();
    step();
    check("t5_repress_count", int'(bus.count), 1);
    check("t5_repress_pending", int'(bus.pending), 'h80);
    bus.btn = '0;
    serve_next(7);
    // press floor 1 in its own pop cycle
    bus.btn = 8'h02;
    step();
    bus.btn = '0;
    wait_target();
    check("t6_target", int'(bus.req_floor), 1);
    bus.stop_in = 1'b1;
    repeat (5) step();
    check("t6_last_hold", int'(bus.req_floor), 1);
    bus.btn = 8'h02;
    step();
    check("t6_pop_req", int'(bus.req_floor), 15);
    bus.btn = '0;
    bus.stop_in = 1'b0;
    step();
    check("t6_drop_count", int'(bus.count), 0);
    check("t6_drop_pending", int'(bus.pending), 0);
    bus.btn = 8'h02;
    step();
    step();
    check("t6_requeue_count", int'(bus.count), 1);
    bus.btn = '0;
    serve_next(1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
